// File: rtl/fifo_sync_param_if.sv
// FIFO data/control bundle: master drives data_in/push/pop/clr, slave returns head data, level and flags.
interface fifo_sync_param_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
);
  localparam int AW = $clog2(DEPTH);

  logic             clr;
  logic [WIDTH-1:0] data_in;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] data_out;
  logic             empty;
  logic             full;
  logic             almost_empty;
  logic             almost_full;
  logic [AW:0]      level;
  logic             overflow;
  logic             underflow;

  modport master (
    output clr, data_in, push, pop,
    input  data_out, empty, full, almost_empty, almost_full, level, overflow, underflow
  );

  modport slave (
    input  clr, data_in, push, pop,
    output data_out, empty, full, almost_empty, almost_full, level, overflow, underflow
  );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised FWFT sync FIFO; FIFO_EDGE_STROBE_EN turns push/pop into rising-edge strobes (one op per assertion).
// Push visible on data_out one edge later; full drops pushes (sticky overflow), empty ignores pops (sticky underflow).
module fifo_sync_param #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 4,
  parameter int AW         = $clog2(DEPTH),
  parameter int AFULL_LVL  = DEPTH - 1,
  parameter int AEMPTY_LVL = 1
) (
  input  logic               clk,
  input  logic               reset_n,
  fifo_sync_param_if.slave   bus
);

  localparam logic [AW:0] LVL_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0] LVL_AFULL  = (AW+1)'(AFULL_LVL);
  localparam logic [AW:0] LVL_AEMPTY = (AW+1)'(AEMPTY_LVL);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp;
  logic [AW-1:0]    rp;
  logic [AW:0]      level;
  logic             overflow;
  logic             underflow;
  logic             push_e;
  logic             pop_e;
  logic             empty;
  logic             full;
  logic             wr;
  logic             rd;

`ifdef FIFO_EDGE_STROBE_EN
  logic push_q;
  logic pop_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      push_q <= 1'b0;
      pop_q  <= 1'b0;
    end else begin
      push_q <= bus.push;
      pop_q  <= bus.pop;
    end
  end

  assign push_e = bus.push & ~push_q;
  assign pop_e  = bus.pop  & ~pop_q;
`else
  assign push_e = bus.push;
  assign pop_e  = bus.pop;
`endif

  assign empty = (level == '0);
  assign full  = (level == LVL_FULL);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
  assign wr    = push_e & (~full | pop_e);
  assign rd    = pop_e & ~empty;

  always_ff @(posedge clk) begin
    if (wr && !bus.clr) begin
      mem[wp] <= bus.data_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else if (bus.clr) begin
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (wr) wp <= wp + AW'(1);
      if (rd) rp <= rp + AW'(1);
      if (wr && !rd)      level <= level + (AW+1)'(1);
      else if (rd && !wr) level <= level - (AW+1)'(1);
      if (push_e && full && !pop_e) overflow  <= 1'b1;
      if (pop_e && empty)           underflow <= 1'b1;
    end
  end

  assign bus.data_out     = empty ? '0 : mem[rp];
  assign bus.empty        = empty;
  assign bus.full         = full;
  assign bus.almost_empty = (level <= LVL_AEMPTY);
  assign bus.almost_full  = (level >= LVL_AFULL);
  assign bus.level        = level;
  assign bus.overflow     = overflow;
  assign bus.underflow    = underflow;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param (WIDTH=8, DEPTH=4); expectations adapt to FIFO_EDGE_STROBE_EN.
module tb_fifo_sync_param;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_err;

  fifo_sync_param_if #(.WIDTH(8), .DEPTH(4)) bus ();

  fifo_sync_param #(.WIDTH(8), .DEPTH(4)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-cycle strobe followed by an idle cycle: a single operation in either strobe mode.
  task automatic op_pulse(input logic p, input logic q, input logic [7:0] d);
    bus.data_in = d;
    bus.push    = p;
    bus.pop     = q;
    tick();
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    tick();
  endtask

  task automatic flush();
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
  endtask

  logic [7:0] model [$];
  logic [7:0] head;

  initial begin
    n_cmp       = 0;
    n_err       = 0;
    reset_n     = 1'b0;
    bus.clr     = 1'b0;
    bus.push    = 1'b0;
    bus.pop     = 1'b0;
    bus.data_in = 8'h00;
    #12;
    chk("rst_level", 32'(bus.level), 0);
    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_full",  32'(bus.full),  0);
    chk("rst_aempty", 32'(bus.almost_empty), 1);
    chk("rst_afull", 32'(bus.almost_full), 0);
    chk("rst_dout",  32'(bus.data_out), 0);
    reset_n = 1'b1;
    tick();

    // Pop from empty FIFO.
    op_pulse(1'b0, 1'b1, 8'h00);
    chk("uf_empty", 32'(bus.empty), 1);
    chk("uf_flag",  32'(bus.underflow), 1);
    chk("uf_level", 32'(bus.level), 0);
    flush();
    chk("uf_clr", 32'(bus.underflow), 0);

    // Push held for 5 cycles.
    bus.data_in = 8'h00;
    bus.push    = 1'b1;
    repeat (5) tick();
    bus.push    = 1'b0;
    tick();
`ifdef FIFO_EDGE_STROBE_EN
    chk("hold_level", 32'(bus.level), 1);
    chk("hold_full",  32'(bus.full), 0);
`else
    chk("hold_level", 32'(bus.level), 4);
    chk("hold_full",  32'(bus.full), 1);
`endif
    chk("hold_empty", 32'(bus.empty), 0);
    flush();

    // Fill, overflow, drain.
    for (int i = 0; i < 4; i++) op_pulse(1'b1, 1'b0, 8'(i));
    chk("fill_full",  32'(bus.full), 1);
    chk("fill_afull", 32'(bus.almost_full), 1);
    chk("fill_level", 32'(bus.level), 4);
    op_pulse(1'b1, 1'b0, 8'h01);
    chk("ovf_flag",  32'(bus.overflow), 1);
    chk("ovf_dout",  32'(bus.data_out), 8'h00);
    chk("ovf_level", 32'(bus.level), 4);
    op_pulse(1'b0, 1'b1, 8'h00);
    chk("drain1", 32'(bus.data_out), 8'h01);
    chk("drain1_afull", 32'(bus.almost_full), 1);
    op_pulse(1'b0, 1'b1, 8'h00);
    chk("drain2", 32'(bus.data_out), 8'h02);
    chk("drain2_afull", 32'(bus.almost_full), 0);
    op_pulse(1'b0, 1'b1, 8'h00);
    chk("drain3", 32'(bus.data_out), 8'h03);
    chk("drain3_aempty", 32'(bus.almost_empty), 1);
    op_pulse(1'b0, 1'b1, 8'h00);
    chk("drain_empty", 32'(bus.empty), 1);
    chk("drain_dout",  32'(bus.data_out), 0);
    chk("drain_uf",    32'(bus.underflow), 0);
    flush();
    chk("clr_ovf", 32'(bus.overflow), 0);

    // Simultaneous push/pop while full, then while empty.
    for (int i = 0; i < 4; i++) op_pulse(1'b1, 1'b0, 8'(8'h10 + i));
    op_pulse(1'b1, 1'b1, 8'hAA);
    chk("fp_level", 32'(bus.level), 4);
    chk("fp_dout",  32'(bus.data_out), 8'h11);
    chk("fp_ovf",   32'(bus.overflow), 0);
    repeat (3) op_pulse(1'b0, 1'b1, 8'h00);
    chk("fp_aa", 32'(bus.data_out), 8'hAA);
    op_pulse(1'b0, 1'b1, 8'h00);
    chk("fp_empty", 32'(bus.empty), 1);
    chk("ep_uf_pre", 32'(bus.underflow), 0);
    op_pulse(1'b1, 1'b1, 8'h55);
    chk("ep_level", 32'(bus.level), 1);
    chk("ep_dout",  32'(bus.data_out), 8'h55);
    chk("ep_uf",    32'(bus.underflow), 1);
    flush();

    // Sustained push+pop across pointer wrap.
    model.delete();
    for (int i = 0; i < 3; i++) begin
      op_pulse(1'b1, 1'b0, 8'(8'h20 + i));
      model.push_back(8'(8'h20 + i));
    end
    for (int i = 0; i < 10; i++) begin
      bus.data_in = 8'(8'h30 + i);
      bus.push    = 1'b1;
      bus.pop     = 1'b1;
      tick();
`ifdef FIFO_EDGE_STROBE_EN
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      tick();
`endif
      head = model.pop_front();
      model.push_back(8'(8'h30 + i));
      chk($sformatf("wrap_dout%0d", i), 32'(bus.data_out), 32'(model[0]));
      chk($sformatf("wrap_lvl%0d", i),  32'(bus.level), 3);
    end
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    tick();
    chk("pre_rst_level", 32'(bus.level), 3);

    // Async reset without a clock edge.
    reset_n = 1'b0;
    #2;
    chk("arst_level",  32'(bus.level), 0);
    chk("arst_empty",  32'(bus.empty), 1);
    chk("arst_dout",   32'(bus.data_out), 0);
    chk("arst_aempty", 32'(bus.almost_empty), 1);
    chk("arst_afull",  32'(bus.almost_full), 0);
    chk("arst_flags",  32'({bus.overflow, bus.underflow}), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
# fifo_sync_param

Parametrised synchronous FIFO, successor to the fixed 8-bit/4-entry `fifo` used between the 68k bus interface and the UART/peripheral blocks. Adds configurable width and depth, an occupancy count, almost-full/almost-empty thresholds, sticky overflow/underflow flags and a synchronous flush. Output is first-word-fall-through: the head entry is always visible on `data_out`.

## Interface
Parameters:
- `WIDTH`, 8, data width in bits (≥1)
- `DEPTH`, 4, number of entries; power of two, ≥2
- `AW`, $clog2(DEPTH), pointer width (derived, not overridden)
- `AFULL_LVL`, DEPTH-1, `almost_full` asserts when `level >= AFULL_LVL`
- `AEMPTY_LVL`, 1, `almost_empty` asserts when `level <= AEMPTY_LVL`

Ports:
- `clk` in 1: single clock, all state on rising edge
- `reset_n` in 1: reset, asynchronous, active-low
- `clr` in 1: synchronous flush, empties FIFO and clears sticky flags
- `data_in` in WIDTH: write data
- `push` in 1: write request
- `pop` in 1: read request
- `data_out` out WIDTH: head entry (FWFT)
- `empty` out 1: no entries
- `full` out 1: DEPTH entries
- `almost_empty` out 1: level ≤ AEMPTY_LVL
- `almost_full` out 1: level ≥ AFULL_LVL
- `level` out AW+1: current entry count, 0..DEPTH
- `overflow` out 1: sticky, push attempted while full
- `underflow` out 1: sticky, pop attempted while empty

## Operation
- Storage: DEPTH×WIDTH register array; write pointer `wp`, read pointer `rp` (AW bits, natural wrap DEPTH-1→0); `level` counter (AW+1 bits).
- Effective strobes `push_e`, `pop_e` (see Configuration).
- Accepted write `wr = push_e & (~full | pop_e)`; accepted read `rd = pop_e & ~empty`.
- `wr`: `mem[wp] <= data_in`, `wp <= wp+1`. `rd`: `rp <= rp+1`.
- `level`: +1 on wr only, −1 on rd only, unchanged on both or neither.
- Full and pop_e and push_e: both accepted, level stays DEPTH, new word written into freed slot.
- Empty and pop_e and push_e: pop rejected (underflow set), push accepted, level → 1.
- Push while full without pop: data dropped, `overflow <= 1`. Pop while empty: `underflow <= 1`. Flags clear only on reset or `clr`.
- `data_out = empty ? 0 : mem[rp]` (combinational from registers).
- `empty = (level == 0)`, `full = (level == DEPTH)`, thresholds combinational from `level`.
- `clr` has priority over push/pop in that cycle: pointers, level, flags → 0; memory contents not cleared.

## Timing
- Reset values: `level`=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0 (AFULL_LVL>0), `data_out`=0, `overflow`=`underflow`=0, pointers 0, edge registers 0.
- Reset asserted mid-operation: all state returns to reset values immediately (async); data lost.
- Write-to-read latency: word pushed at edge N visible on `data_out` and `empty`=0 after edge N (same cycle as level update).
- Pop at edge N: next entry on `data_out` after edge N.
- All flags update in the cycle after the accepting edge; no combinational path from `push`/`pop` to any output.

## Configuration
- `FIFO_EDGE_STROBE_EN` defined: `push_e = push & ~push_q`, `pop_e = pop & ~pop_q` (registered previous values, reset 0). A strobe held for any number of cycles performs exactly one operation; a strobe high when reset releases counts as one edge. Compatible with legacy bus-driven strobes.
- Not defined: `push_e = push`, `pop_e = pop`; one operation per cycle the strobe is high (streaming mode).

## Test plan
- Reset, then pop 1 cycle -> `empty`=1, `underflow`=1, `level`=0; `clr` 1 cycle -> `underflow`=0.
- Edge mode, DEPTH=4: push 0x00 held 5 cycles -> `level`=1, `empty`=0, `full`=0; level mode same stimulus -> `level`=4, `full`=1.
- Push 0x00,0x01,0x02,0x03 -> `full`=1, `almost_full`=1; push 0x01 -> dropped, `overflow`=1, `data_out`=0x00; pops yield 0x01,0x02,0x03 then `empty`=1, `data_out`=0.
- Full FIFO, simultaneous push 0xAA and pop -> `level` stays 4, after 3 pops `data_out`=0xAA; empty FIFO, simultaneous push 0x55 and pop -> `level`=1, `data_out`=0x55, `underflow`=1.
- Level mode, 10 push/pop cycles with DEPTH=4 -> pointer wrap, data order preserved, `level` constant.
- Assert `reset_n`=0 with `level`=3 -> outputs at reset values without waiting for `clk`.
